freq_meter_ctrl: RTL

Measurement sequencer for the digital frequency meter. It takes the five divided test clocks (500 kHz down to 31.25 kHz) from the on-chip divider chain and selects one of them, or scans all five in turn. For each source it counts rising edges over a fixed gate window and publishes the count with a one-cycle valid strobe. It sits between the divider chain and the display/readout logic, and owns source selection, gate timing and result latching.

---
 rtl/freq_meter_pkg.sv | 20 ++
 rtl/sig_edge_sync.sv | 28 ++
 rtl/freq_meter_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter sequencer.
// Covers the FSM state encoding, the source count and the source-index fold.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        LATCH  = 2'd3
    } state_t;

    localparam int NUM_SRC   = 5;
    localparam int SRC_IDX_W = 3;

    // Out-of-range selections map to the fastest source
    function automatic logic [SRC_IDX_W-1:0] fold_idx(input logic [SRC_IDX_W-1:0] idx);
        return (idx >= SRC_IDX_W'(NUM_SRC)) ? '0 : idx;
    endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchronizer for an asynchronous input, followed by a rising-edge detector.
// The rise output is high for one cycle when the synchronized level goes from 0 to 1.
module sig_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= sig;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/freq_meter_ctrl.sv
// Frequency meter sequencer: selects or scans the divided clocks, counts rising edges
// over a fixed gate window and publishes each count with a one-cycle valid strobe.
module freq_meter_ctrl
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = 1_000_000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   src_in,
    input  logic                 start,
    input  logic                 scan,
    input  logic [SRC_IDX_W-1:0] src_sel,
    input  logic                 abort,
    output logic                 busy,
    output logic                 result_valid,
    output logic [CNT_W-1:0]     freq_cnt,
    output logic [SRC_IDX_W-1:0] freq_idx,
    output logic                 overflow
);

    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0]     GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
    localparam logic [SRC_IDX_W-1:0] LAST_IDX    = SRC_IDX_W'(NUM_SRC - 1);

    state_t               state_reg;
    logic [TMR_W-1:0]     timer_reg;
    logic [SRC_IDX_W-1:0] idx_reg;
    logic                 scan_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    logic                 ovf_reg;
    logic                 ovf_next;
    logic                 src_mux;
    logic                 src_rise;

    // idx_reg is always folded into 0..NUM_SRC-1, so the select stays in range
    assign src_mux = src_in[idx_reg];

    sig_edge_sync u_edge_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (src_mux),
        .rise (src_rise)
    );

    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (src_rise) begin
            if (cnt_reg == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            idx_reg      <= '0;
            scan_reg     <= 1'b0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            freq_cnt     <= '0;
            freq_idx     <= '0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (abort) begin
                // Also masks a simultaneous start while IDLE
                state_reg <= IDLE;
                timer_reg <= '0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            scan_reg  <= scan;
                            idx_reg   <= scan ? '0 : fold_idx(src_sel);
                            timer_reg <= SETTLE_LOAD;
                            state_reg <= SETTLE;
                            busy      <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (timer_reg == '0) begin
                            state_reg <= GATE;
                            timer_reg <= GATE_LOAD;
                            cnt_reg   <= '0;
                            ovf_reg   <= 1'b0;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end
                    GATE: begin
                        cnt_reg <= cnt_next;
                        ovf_reg <= ovf_next;
                        if (timer_reg == '0) begin
                            // Publish including any edge seen on the final gate cycle
                            state_reg    <= LATCH;
                            timer_reg    <= '0;
                            freq_cnt     <= cnt_next;
                            overflow     <= ovf_next;
                            freq_idx     <= idx_reg;
                            result_valid <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end
                    LATCH: begin
                        if (scan_reg && (idx_reg != LAST_IDX)) begin
                            idx_reg   <= idx_reg + 1'b1;
                            timer_reg <= SETTLE_LOAD;
                            state_reg <= SETTLE;
                        end else begin
                            timer_reg <= '0;
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        timer_reg <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
